slow_sequencer: RTL and testbench

Sequences the accelerator's drop to slow (motherboard-speed) timing for accesses to slow I/O devices. Qualifies each bus access against the per-device slow-enable bits and timeout held in the configuration register block. It then runs a request/acknowledge handshake with the clock switch and stalls the CPU cycle until slow mode is established. After the access it holds slow mode for a programmable number of timebase ticks before releasing it.

---
 rtl/slow_pkg.sv | 6 +
 rtl/slow_holdcnt.sv | 25 ++
 rtl/slow_sequencer.sv | 84 ++++++++
 tb/tb_slow_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/slow_pkg.sv
// slow_pkg: shared state encoding and timeout constants for the slow-mode sequencer
package slow_pkg;
  localparam int TO_W = 4;
  localparam logic [TO_W-1:0] TO_INF = 4'hF;
  typedef enum logic [2:0] {IDLE, REQ, ACTIVE, HOLD, DROP} state_t;
endpackage

// File: rtl/slow_holdcnt.sv
// slow_holdcnt: loadable hold-time down-counter with Tick decrement, infinite-code inhibit and expire flag
// Ports: i_clk/i_rst_n clock and async active-low reset; i_load/i_load_val load the count;
//        i_dec_en permits a decrement on i_tick; o_expire flags the tick that consumes the last unit.
module slow_holdcnt #(
  parameter int TO_W = slow_pkg::TO_W,
  parameter logic [TO_W-1:0] TO_INF = slow_pkg::TO_INF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic [TO_W-1:0] i_load_val,
  input  logic            i_dec_en,
  input  logic            i_tick,
  output logic            o_expire
);
  import slow_pkg::*;
  logic [TO_W-1:0] r_cnt;
  logic            w_step;
  assign w_step   = i_dec_en & i_tick;
  assign o_expire = w_step & (r_cnt == TO_W'(1));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (w_step & (r_cnt != TO_INF)) r_cnt <= r_cnt - 1'b1;
endmodule

// File: rtl/slow_sequencer.sv
// slow_sequencer: qualifies slow-device accesses, handshakes slow mode with the clock switch and holds it for a timeout
// Ports: CLK/nPOR clock and async active-low reset; BACT plus six device selects and matching Slow* enables
//        form the qualifier; SlowTimeout/Tick set the hold time; SlowAck is the clock-switch reply;
//        SlowReq requests slow mode, SlowWait stalls the CPU cycle.
// Build option SLOW_CLKGATE_EN adds ClkGateEn, a registered fast-clock gate controlled by SlowClockGate.
module slow_sequencer #(
  parameter int TO_W = slow_pkg::TO_W,
  parameter logic [TO_W-1:0] TO_INF = slow_pkg::TO_INF
) (
  input  logic            CLK,
  input  logic            nPOR,
  input  logic            BACT,
  input  logic            IACKCyc,
  input  logic            VIACS,
  input  logic            IWMCS,
  input  logic            SCCCS,
  input  logic            SCSICS,
  input  logic            SndCS,
  input  logic            SlowIACK,
  input  logic            SlowVIA,
  input  logic            SlowIWM,
  input  logic            SlowSCC,
  input  logic            SlowSCSI,
  input  logic            SlowSnd,
  input  logic            SlowClockGate,
  input  logic [TO_W-1:0] SlowTimeout,
  input  logic            Tick,
  input  logic            SlowAck,
  output logic            SlowReq,
`ifdef SLOW_CLKGATE_EN
  output logic            ClkGateEn,
`endif
  output logic            SlowWait
);
  import slow_pkg::*;
  state_t r_state, w_next;
  logic   w_qual, w_est, w_next_est, w_expire, w_req, r_wait;
  assign w_qual = BACT & |({SndCS, SCSICS, SCCCS, IWMCS, VIACS, IACKCyc} &
                           {SlowSnd, SlowSCSI, SlowSCC, SlowIWM, SlowVIA, SlowIACK});
  assign w_est      = (r_state == ACTIVE) | (r_state == HOLD);
  assign w_next_est = (w_next == ACTIVE) | (w_next == HOLD);
  slow_holdcnt #(.TO_W(TO_W), .TO_INF(TO_INF)) u_cnt (
    .i_clk      (CLK),
    .i_rst_n    (nPOR),
    .i_load     ((r_state == ACTIVE) & ~BACT),
    .i_load_val (SlowTimeout),
    .i_dec_en   ((r_state == HOLD) & ~w_qual),
    .i_tick     (Tick),
    .o_expire   (w_expire)
  );
  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    case (r_state)
      IDLE:    w_next = w_qual ? REQ : IDLE;
      REQ:     begin w_req = 1'b1; w_next = SlowAck ? ACTIVE : REQ; end
      ACTIVE:  begin w_req = 1'b1; w_next = BACT ? ACTIVE : (SlowTimeout == '0) ? DROP : HOLD; end
      HOLD:    begin w_req = 1'b1; w_next = w_qual ? ACTIVE : w_expire ? DROP : HOLD; end
      DROP:    w_next = SlowAck ? DROP : w_qual ? REQ : IDLE;
      default: w_next = IDLE;
    endcase
  end
  assign SlowReq  = w_req;
  assign SlowWait = r_wait;
  always_ff @(posedge CLK or negedge nPOR)
    if (!nPOR) begin
      r_state <= IDLE;
      r_wait  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_qual & ~w_est;
    end
`ifdef SLOW_CLKGATE_EN
  logic r_gate;
  assign ClkGateEn = r_gate;
  // Keyed off the next state so the gate opens on the very edge that enters DROP.
  always_ff @(posedge CLK or negedge nPOR)
    if (!nPOR) r_gate <= 1'b1;
    else r_gate <= ~(SlowClockGate & w_next_est);
`else
  logic w_unused;
  assign w_unused = SlowClockGate ^ w_next_est;
`endif
endmodule

// File: tb/tb_slow_sequencer.sv
// tb_slow_sequencer: randomized scoreboard bench for slow_sequencer against a behavioural model
module tb_slow_sequencer;
  logic       CLK = 1'b0, nPOR = 1'b1, BACT = 1'b0, SlowAck = 1'b0, Tick = 1'b0, SlowClockGate = 1'b0;
  logic [5:0] sel = '0, en = 6'h3F;
  logic [3:0] to = 4'd3;
  logic       SlowReq, SlowWait;
`ifdef SLOW_CLKGATE_EN
  logic       ClkGateEn;
`endif
  int  n_cmp = 0, n_bad = 0, tick_div = 0;
  bit  rand_cfg = 0, in_rst = 1;
  logic [2:0] sb_q[$];
  bit  m_req, m_granted, m_busy, m_drain, m_wait, m_gate = 1;
  int  m_left;

  always #5 CLK = ~CLK;

  slow_sequencer dut (
    .CLK(CLK), .nPOR(nPOR), .BACT(BACT),
    .IACKCyc(sel[0]), .VIACS(sel[1]), .IWMCS(sel[2]), .SCCCS(sel[3]), .SCSICS(sel[4]), .SndCS(sel[5]),
    .SlowIACK(en[0]), .SlowVIA(en[1]), .SlowIWM(en[2]), .SlowSCC(en[3]), .SlowSCSI(en[4]), .SlowSnd(en[5]),
    .SlowClockGate(SlowClockGate), .SlowTimeout(to), .Tick(Tick), .SlowAck(SlowAck),
    .SlowReq(SlowReq),
`ifdef SLOW_CLKGATE_EN
    .ClkGateEn(ClkGateEn),
`endif
    .SlowWait(SlowWait)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: slow mode is requested for a qualifying access, granted once the switch acks,
  // kept while the access runs, then held for the sampled number of ticks (15 = forever).
  function automatic void model_step();
    bit q = BACT && |(sel & en);
    m_wait = q && !(m_req && m_granted);
    if (!m_req && !m_drain) m_req = q;
    else if (m_req && !m_granted) begin
      m_granted = SlowAck;
      m_busy    = SlowAck;
    end else if (m_busy) begin
      if (!BACT) begin
        m_busy = 0;
        m_left = (to == 4'hF) ? -1 : int'(to);
        if (to == 0) {m_req, m_granted, m_drain} = 3'b001;
      end
    end else if (m_req) begin
      if (q) m_busy = 1;
      else if (Tick && m_left > 0) begin
        m_left--;
        if (m_left == 0) {m_req, m_granted, m_drain} = 3'b001;
      end
    end else if (!SlowAck) begin
      m_drain = 0;
      m_req   = q;
    end
    m_gate = !(m_req && m_granted && SlowClockGate);
  endfunction

  task automatic cycle();
    @(posedge CLK);
    model_step();
    sb_q.push_back({m_req, m_wait, m_gate});
    #1;
    if (SlowAck != SlowReq && $urandom_range(1, 0) == 1) SlowAck = SlowReq;
    Tick = (tick_div == 0) ? 1'b0 : ($urandom_range(tick_div - 1, 0) == 0);
    if (rand_cfg) begin
      if ($urandom_range(15, 0) == 0) to = 4'($urandom_range(15, 0));
      if ($urandom_range(15, 0) == 0) en = 6'($urandom);
      if ($urandom_range(15, 0) == 0) SlowClockGate = ~SlowClockGate;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic access(input logic [5:0] s, input int len, input bit abort);
    int i;
    sel  = s;
    BACT = 1'b1;
    for (i = 0; i < 300 && (i < len || (SlowWait && !abort)); i++) cycle();
    if (!abort) chk("wait_released", SlowWait, 1'b0);
    BACT = 1'b0;
    sel  = '0;
  endtask

  task automatic do_reset();
    in_rst = 1;
    #2 nPOR = 1'b0;
    #1;
    chk("rst_SlowReq", SlowReq, 1'b0);
    chk("rst_SlowWait", SlowWait, 1'b0);
`ifdef SLOW_CLKGATE_EN
    chk("rst_ClkGateEn", ClkGateEn, 1'b1);
`endif
    sb_q.delete();
    BACT = 1'b0; sel = '0; SlowAck = 1'b0; Tick = 1'b0;
    {m_req, m_granted, m_busy, m_drain, m_wait} = '0;
    m_gate = 1; m_left = 0;
    repeat (2) @(posedge CLK);
    #1 nPOR = 1'b1;
    sb_q.push_back(3'b001);
    in_rst = 0;
  endtask

  always @(negedge CLK) begin
    logic [2:0] e;
    if (!in_rst) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_underflow: got empty queue expected one entry at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("SlowReq", SlowReq, e[2]);
        chk("SlowWait", SlowWait, e[1]);
`ifdef SLOW_CLKGATE_EN
        chk("ClkGateEn", ClkGateEn, e[0]);
`endif
      end
    end
  end

  initial begin
    do_reset();
    idle(2);
    SlowClockGate = 1'b1;
    access(6'b000010, 4, 0);
    to = 4'd3; tick_div = 3;
    idle(30);
    tick_div = 0;
    access(6'b000010, 3, 0);
    idle(2);
    Tick = 1'b1; cycle();
    to = 4'd5;
    Tick = 1'b1;
    access(6'b001000, 3, 0);
    idle(2);
    repeat (6) begin Tick = 1'b1; cycle(); idle(1); end
    idle(4);
    to = 4'hF; tick_div = 1;
    access(6'b000010, 3, 0);
    idle(100);
    to = 4'd0; tick_div = 0;
    access(6'b100000, 3, 0);
    idle(6);
    SlowClockGate = 1'b0;
    en = 6'b101111;
    access(6'b010000, 5, 0);
    idle(3);
    en = 6'h3F; to = 4'hF;
    access(6'b000001, 3, 0);
    idle(5);
    do_reset();
    idle(2);
    BACT = 1'b1; sel = 6'b000100;
    idle(1);
    BACT = 1'b0; sel = '0;
    idle(12);
    rand_cfg = 1; tick_div = 3; to = 4'd2;
    repeat (150) begin
      access(($urandom_range(7, 0) == 0) ? 6'b0 : 6'(1 << $urandom_range(5, 0)),
             $urandom_range(6, 1), $urandom_range(19, 0) == 0);
      idle($urandom_range(25, 0));
    end
    idle(3);
    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
